// File: rtl/reg_cmd_sequencer.sv
// ============================================================================
// Module   : reg_cmd_sequencer
// Brief    : Two-requester round-robin LOAD/UP/DOWN sequencer for one ld/inc/dec register.
//            Optional boundary saturation: define REG_SEQ_SATURATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_cmd_sequencer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [1:0]        req0_op,
  input  logic [DATA_W-1:0] req0_arg,
  input  logic              req1_valid,
  input  logic [1:0]        req1_op,
  input  logic [DATA_W-1:0] req1_arg,
  output logic              ack0,
  output logic              ack1,
  output logic              done0,
  output logic              done1,
  output logic              busy,
  input  logic [DATA_W-1:0] reg_q,
  output logic              reg_ld,
  output logic              reg_inc,
  output logic              reg_dec,
  output logic [DATA_W-1:0] reg_in,
  output logic              sat
);

  localparam logic [1:0] c_OP_LOAD = 2'b00;
  localparam logic [1:0] c_OP_UP   = 2'b01;
  localparam logic [1:0] c_OP_DOWN = 2'b10;
  localparam logic [DATA_W-1:0] c_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_rr;
  logic              r_owner;
  logic [1:0]        r_op;
  logic [DATA_W-1:0] r_cnt;
  logic              r_ack0;
  logic              r_ack1;
  logic              r_done0;
  logic              r_done1;
  logic              r_ld;
  logic              r_inc;
  logic              r_dec;
  logic [DATA_W-1:0] r_in;
  logic              r_sat;

  logic              w_any;
  logic              w_grant1;
  logic              w_stop_up;
  logic              w_stop_down;

  assign w_any    = req0_valid | req1_valid;
  assign w_grant1 = req1_valid & (~req0_valid | r_rr);

`ifdef REG_SEQ_SATURATE_EN
  // A strobe issued last cycle only lands in reg_q at this edge, so look ahead by it.
  logic [DATA_W-1:0] w_q_eff;
  assign w_q_eff     = reg_q + DATA_W'(r_inc) - DATA_W'(r_dec);
  assign w_stop_up   = &w_q_eff;
  assign w_stop_down = ~|w_q_eff;
`else
  logic w_unused_q;
  assign w_unused_q  = ^reg_q;
  assign w_stop_up   = 1'b0;
  assign w_stop_down = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_rr    <= 1'b0;
      r_owner <= 1'b0;
      r_op    <= 2'b00;
      r_cnt   <= '0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_ld    <= 1'b0;
      r_inc   <= 1'b0;
      r_dec   <= 1'b0;
      r_in    <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_ld    <= 1'b0;
      r_inc   <= 1'b0;
      r_dec   <= 1'b0;
      r_in    <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner <= w_grant1;
            r_rr    <= ~w_grant1;
            r_op    <= w_grant1 ? req1_op  : req0_op;
            r_cnt   <= w_grant1 ? req1_arg : req0_arg;
            r_ack0  <= ~w_grant1;
            r_ack1  <= w_grant1;
            r_sat   <= 1'b0;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          // r_cnt holds the LOAD value or the remaining step count.
          case (r_op)
            c_OP_LOAD: begin
              r_ld    <= 1'b1;
              r_in    <= r_cnt;
              r_state <= S_DONE;
            end
            c_OP_UP: begin
              if (r_cnt == '0) begin
                r_state <= S_DONE;
              end else if (w_stop_up) begin
                r_sat   <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_inc <= 1'b1;
                r_cnt <= r_cnt - c_ONE;
              end
            end
            c_OP_DOWN: begin
              if (r_cnt == '0) begin
                r_state <= S_DONE;
              end else if (w_stop_down) begin
                r_sat   <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_dec <= 1'b1;
                r_cnt <= r_cnt - c_ONE;
              end
            end
            default: r_state <= S_DONE;
          endcase
        end
        S_DONE: begin
          r_done0 <= ~r_owner;
          r_done1 <= r_owner;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack0    = r_ack0;
  assign ack1    = r_ack1;
  assign done0   = r_done0;
  assign done1   = r_done1;
  assign busy    = (r_state != S_IDLE);
  assign reg_ld  = r_ld;
  assign reg_inc = r_inc;
  assign reg_dec = r_dec;
  assign reg_in  = r_in;
  assign sat     = r_sat;

endmodule

`default_nettype wire

// File: tb/tb_reg_cmd_sequencer.sv
// ============================================================================
// Module   : tb_reg_cmd_sequencer
// Brief    : Directed bench for reg_cmd_sequencer with a behavioural register model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_cmd_sequencer;

  localparam logic [1:0] c_LOAD = 2'b00;
  localparam logic [1:0] c_UP   = 2'b01;
  localparam logic [1:0] c_DOWN = 2'b10;
  localparam logic [1:0] c_NOP  = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0_valid, req1_valid;
  logic [1:0] req0_op, req1_op;
  logic [7:0] req0_arg, req1_arg;
  logic       ack0, ack1, done0, done1, busy;
  logic       reg_ld, reg_inc, reg_dec, sat;
  logic [7:0] reg_in;
  logic [7:0] q = 8'h00;

  int checks = 0;
  int errors = 0;

  reg_cmd_sequencer #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_arg(req0_arg),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_arg(req1_arg),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1), .busy(busy),
    .reg_q(q), .reg_ld(reg_ld), .reg_inc(reg_inc), .reg_dec(reg_dec),
    .reg_in(reg_in), .sat(sat)
  );

  always #5 clk = ~clk;

  // Register being sequenced: ld has priority, then inc, then dec; wraps naturally.
  always @(posedge clk) begin
    if (reg_ld)       q <= reg_in;
    else if (reg_inc) q <= q + 8'd1;
    else if (reg_dec) q <= q - 8'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    int n;
    @(negedge clk);
    n = int'(reg_ld) + int'(reg_inc) + int'(reg_dec);
    chk("one_strobe", 32'(n <= 1), 32'd1);
  endtask

  task automatic issue(input int r, input logic [1:0] op, input logic [7:0] arg);
    logic got;
    if (r == 0) begin req0_valid = 1'b1; req0_op = op; req0_arg = arg; end
    else        begin req1_valid = 1'b1; req1_op = op; req1_arg = arg; end
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      cyc();
      if ((r == 0) ? ack0 : ack1) got = 1'b1;
    end
    chk("ack_seen", 32'(got), 32'd1);
    chk("ack_other", 32'((r == 0) ? ack1 : ack0), 32'd0);
    chk("busy_at_ack", 32'(busy), 32'd1);
    chk("sat_cleared_at_ack", 32'(sat), 32'd0);
    // Scramble the command after capture; it must have no effect.
    if (r == 0) begin req0_valid = 1'b0; req0_op = 2'b10; req0_arg = 8'hA5; end
    else        begin req1_valid = 1'b0; req1_op = 2'b10; req1_arg = 8'hA5; end
  endtask

  task automatic run(input int r, input logic [1:0] op, input logic [7:0] arg,
                     input int elat, input int eld, input int einc, input int edec,
                     input logic [7:0] eq, input logic esat, input string tag);
    int lat, nld, ninc, ndec;
    lat = 0; nld = 0; ninc = 0; ndec = 0;
    issue(r, op, arg);
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      cyc();
      if (reg_ld) begin
        nld++;
        chk({tag, "_reg_in"}, 32'(reg_in), 32'(arg));
      end
      ninc += int'(reg_inc);
      ndec += int'(reg_dec);
      chk({tag, "_wrong_done"}, 32'((r == 0) ? done1 : done0), 32'd0);
      if ((r == 0) ? done0 : done1) lat = k;
      else chk({tag, "_busy"}, 32'(busy), 32'd1);
    end
    chk({tag, "_latency"}, 32'(lat), 32'(elat));
    chk({tag, "_n_ld"},  32'(nld),  32'(eld));
    chk({tag, "_n_inc"}, 32'(ninc), 32'(einc));
    chk({tag, "_n_dec"}, 32'(ndec), 32'(edec));
    chk({tag, "_reg_q"}, 32'(q), 32'(eq));
    chk({tag, "_sat"},   32'(sat), 32'(esat));
    chk({tag, "_idle_at_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int ninc;
    logic got;
    logic exp0;
    req0_valid = 1'b0; req0_op = 2'b00; req0_arg = 8'h00;
    req1_valid = 1'b0; req1_op = 2'b00; req1_arg = 8'h00;

    cyc(); cyc();
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_ack1", 32'(ack1), 32'd0);
    chk("rst_done0", 32'(done0), 32'd0);
    chk("rst_done1", 32'(done1), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobes", 32'({reg_ld, reg_inc, reg_dec}), 32'd0);
    chk("rst_reg_in", 32'(reg_in), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    rst = 1'b1;
    cyc();

    run(0, c_LOAD, 8'h3C, 2, 1, 0, 0, 8'h3C, 1'b0, "load3c");
    run(0, c_UP,   8'd3,  5, 0, 3, 0, 8'h3F, 1'b0, "up3");
    run(1, c_DOWN, 8'd0,  2, 0, 0, 0, 8'h3F, 1'b0, "down0");
    run(1, c_DOWN, 8'd2,  4, 0, 0, 2, 8'h3D, 1'b0, "down2");
    run(0, c_NOP,  8'h55, 2, 0, 0, 0, 8'h3D, 1'b0, "nop");
    run(1, c_LOAD, 8'hFE, 2, 1, 0, 0, 8'hFE, 1'b0, "loadfe");
`ifdef REG_SEQ_SATURATE_EN
    run(0, c_UP,   8'd3,  3, 0, 1, 0, 8'hFF, 1'b1, "up_sat");
`else
    run(0, c_UP,   8'd3,  5, 0, 3, 0, 8'h01, 1'b0, "up_wrap");
`endif
    run(1, c_LOAD, 8'h01, 2, 1, 0, 0, 8'h01, 1'b0, "load01");
`ifdef REG_SEQ_SATURATE_EN
    run(1, c_DOWN, 8'd4,  3, 0, 0, 1, 8'h00, 1'b1, "down_sat");
`else
    run(1, c_DOWN, 8'd4,  6, 0, 0, 4, 8'hFD, 1'b0, "down_wrap");
`endif
    // Leave the pointer on req1 so the post-reset grant proves it was reset.
    run(0, c_LOAD, 8'h10, 2, 1, 0, 0, 8'h10, 1'b0, "load10");

    issue(0, c_UP, 8'd5);
    ninc = 0;
    for (int k = 0; k < 20 && ninc < 2; k++) begin
      cyc();
      if (reg_inc) ninc++;
    end
    chk("mid_second_inc", 32'(ninc), 32'd2);
    rst = 1'b0;
    #1;
    chk("mid_rst_inc", 32'(reg_inc), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done0", 32'(done0), 32'd0);
    chk("mid_rst_reg_in", 32'(reg_in), 32'd0);
    cyc(); cyc();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("mid_no_done", 32'({done0, done1}), 32'd0);
      chk("mid_no_strobe", 32'({reg_ld, reg_inc, reg_dec}), 32'd0);
    end

    req0_valid = 1'b1; req0_op = c_NOP; req0_arg = 8'h00;
    req1_valid = 1'b1; req1_op = c_NOP; req1_arg = 8'h00;
    for (int g = 0; g < 4; g++) begin
      got = 1'b0;
      exp0 = (g % 2 == 0);
      for (int k = 0; k < 10 && !got; k++) begin
        cyc();
        if (ack0 | ack1) begin
          got = 1'b1;
          chk("rr_single_ack", 32'(ack0 & ack1), 32'd0);
          chk("rr_order_ack0", 32'(ack0), 32'(exp0));
        end
      end
      chk("rr_grant_seen", 32'(got), 32'd1);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int k = 0; k < 4; k++) cyc();
    chk("final_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
